timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped timer/counter device on the CPU data bus, downstream of the `mips` core's `m_data_*` port through the system bridge. Counts down from a programmed preset and raises an interrupt request that the bridge ORs into the core's `interrupt` input. Supports a one-shot mode and an auto-reload periodic mode. The CPU programs it with `sw`/`sb`/`sh` and reads it with `lw`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  bridge chip-select; device addressed this cycle.
- `addr`  in  2  word index, `m_data_addr[3:2]` (0 CTRL, 1 PRESET, 2 COUNT, 3 unused).
- `byteen`  in  4  write byte enables from `m_data_byteen`; write when `sel && |byteen`.
- `wdata`  in  32  write data, byte lanes aligned as on `m_data_wdata`.
- `rdata`  out  32  combinational read of the addressed register.
- `irq`  out  1  interrupt request, `irq_flag & CTRL[3]`.

## Operation
- Registers:
  - CTRL: bit0 EN, bits[2:1] MODE, bit3 IM. Bits[31:4] not stored and read 0.
  - PRESET: 32 bits, read/write.
  - COUNT: 32 bits, read-only. Writes ignored.
  - Index 3: reads 0, writes ignored.
- Write to CTRL or PRESET:
  - Register updates at the next edge.
  - Same edge forces state to IDLE and clears `irq_flag`. This overrides any transition that edge.
- States:
  - IDLE: if EN, go to LOAD. Otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE with COUNT held.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1), COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT:
    - MODE 1: `irq_flag` <= 0; go to LOAD if EN, else IDLE.
    - MODE 0, 2, 3: EN <= 0; go to IDLE; `irq_flag` stays 1 until the next CTRL/PRESET write or reset.
- No underflow: COUNT never wraps below 0.
- Arithmetic is unsigned 32-bit.

## Timing
- Reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, so `irq`=0 and `rdata`=0.
- Read latency is 0 cycles (combinational). A read in the same cycle as a write returns the old value.
- Let edge E0 be the edge that writes CTRL with EN=1, with PRESET=N already stored:
  - E1: IDLE→LOAD.
  - E2: COUNT=N.
  - COUNT then decrements once per edge.
  - For N≥1, `irq_flag` rises at edge E(N+2).
  - N=0 and N=1 both raise it at E3.
- MODE 1:
  - `irq_flag` is high for exactly one cycle.
  - Period is max(N,1)+2 cycles.
- MODE 0: `irq` stays high (with IM=1) until software writes CTRL or PRESET.
- IM only gates the output. Changing IM via a CTRL write also clears `irq_flag`, per the write rule above.
- Clearing EN mid-count freezes COUNT. Re-enabling goes IDLE→LOAD, so the count restarts from PRESET rather than resuming.
- Reset mid-count takes priority over everything.

## Configuration
- Macro `TC_BYTEEN_EN`.
- Defined: each set `byteen[i]` merges `wdata` byte i into the addressed register. Only CTRL bits[3:0] are kept. Partial writes still trigger the write rule.
- Undefined: any nonzero `byteen` writes the full 32-bit word; individual lanes are ignored.

## Test plan
- Reset high for 2 cycles → `irq`=0, `rdata` reads 0 at addr 0, 1, 2.
- PRESET=5, then CTRL=0x9 (EN, MODE 0, IM) → COUNT reads 5,4,3,2,1,0 on successive cycles from E2. `irq` rises at E7 and stays high. CTRL then reads 0x8. A later CTRL write drops `irq` next edge.
- PRESET=3, CTRL=0xB (MODE 1, IM) → `irq` is a one-cycle pulse every 5 cycles, first at E5. Pulses continue while EN=1.
- PRESET=0, CTRL=0x9 → `irq` at E3. Repeat with IM=0 → `irq` stays 0 while COUNT reaches 0 and EN clears.
- Mid-count: CTRL=0x0 at COUNT=7 → COUNT holds 7. Writing COUNT (addr 2) has no effect. CTRL=0x9 again → COUNT reloads PRESET at E2.
- `TC_BYTEEN_EN`:
  - Defined: PRESET=0x11223344, then `byteen`=0010 with wdata 0x0000AA00 → PRESET reads 0x1122AA44.
  - Undefined: same stimulus → PRESET reads 0x0000AA00.

Source files
------------

// File: rtl/timer_counter_if.sv
// CPU data-bus port of the timer: chip-select, word index, byte enables, write data, read data, interrupt.
// Combinational read path; no flow control, the device accepts every selected access.
interface timer_counter_if;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, addr, byteen, wdata, input rdata, irq);
    modport slave  (input sel, addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Down-counting timer with one-shot/periodic modes and a maskable interrupt; TC_BYTEEN_EN enables byte-lane writes.
// Latency: reads are combinational; writes land on the next edge; irq rises PRESET+2 edges after enabling.
// Backpressure: none, every selected access completes in the cycle it is presented.
module timer_counter (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        wr_en;
    logic [31:0] wr_word;

    assign wr_en = bus.sel && (|bus.byteen);

`ifdef TC_BYTEEN_EN
    logic [31:0] old_word;
    always_comb begin
        old_word = (bus.addr == A_PRESET) ? preset_q : {28'd0, ctrl_q};
        wr_word  = old_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.byteen[i]) begin
                wr_word[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end
`else
    assign wr_word = bus.wdata;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == 2'd1) begin
                    irq_flag_d = 1'b0;
                    state_d    = ctrl_q[0] ? S_LOAD : S_IDLE;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A CTRL/PRESET write discards whatever the FSM planned this edge, COUNT included.
        if (wr_en && (bus.addr == A_CTRL || bus.addr == A_PRESET)) begin
            state_d    = S_IDLE;
            irq_flag_d = 1'b0;
            count_d    = count_q;
            ctrl_d     = ctrl_q;
            if (bus.addr == A_CTRL) begin
                ctrl_d = wr_word[3:0];
            end else begin
                preset_d = wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        case (bus.addr)
            A_CTRL:   bus.rdata = {28'd0, ctrl_q};
            A_PRESET: bus.rdata = preset_q;
            A_COUNT:  bus.rdata = count_q;
            default:  bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, periodic, zero preset, masking, freeze/reload and byte-lane writes.
module tb_timer_counter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.sel    = 1'b1;
        bus.addr   = a;
        bus.wdata  = d;
        bus.byteen = be;
        tick();
        bus.sel    = 1'b0;
        bus.byteen = 4'd0;
    endtask

    initial begin
        logic [31:0] r;
        total = 0;
        bad   = 0;
        bus.sel    = 1'b0;
        bus.addr   = 2'd0;
        bus.byteen = 4'd0;
        bus.wdata  = 32'd0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
        rd(2'd1, r); chk("rst_preset", r, 32'd0);
        rd(2'd2, r); chk("rst_count", r, 32'd0);

        // One-shot, PRESET=5
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick();
        tick();
        for (int i = 0; i <= 5; i++) begin
            rd(2'd2, r); chk($sformatf("os_count%0d", i), r, 32'(5 - i));
            chk($sformatf("os_irq%0d", i), {31'd0, bus.irq}, (i == 5) ? 32'd1 : 32'd0);
            if (i < 5) tick();
        end
        tick();
        chk("os_irq_hold", {31'd0, bus.irq}, 32'd1);
        rd(2'd0, r); chk("os_ctrl_en_clr", r, 32'h8);
        tick();
        tick();
        chk("os_irq_hold2", {31'd0, bus.irq}, 32'd1);
        wr(2'd0, 32'h8, 4'hF);
        chk("os_irq_clr", {31'd0, bus.irq}, 32'd0);

        // Periodic, PRESET=3: pulses at E5, E10, E15
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("per_irq_e%0d", k), {31'd0, bus.irq},
                (k == 5 || k == 10 || k == 15) ? 32'd1 : 32'd0);
        end
        wr(2'd0, 32'h0, 4'hF);

        // PRESET=0 fires at E3
        wr(2'd1, 32'd0, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick(); chk("z_irq_e1", {31'd0, bus.irq}, 32'd0);
        tick(); chk("z_irq_e2", {31'd0, bus.irq}, 32'd0);
        rd(2'd2, r); chk("z_count_e2", r, 32'd0);
        tick(); chk("z_irq_e3", {31'd0, bus.irq}, 32'd1);

        // Masked: IM=0
        wr(2'd0, 32'h1, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("m_irq_e%0d", k), {31'd0, bus.irq}, 32'd0);
        end
        rd(2'd0, r); chk("m_ctrl_en_clr", r, 32'h0);

        // Freeze at COUNT=7, COUNT writes ignored, re-enable reloads
        wr(2'd1, 32'd20, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick();
        tick();
        rd(2'd2, r); chk("f_count_e2", r, 32'd20);
        for (int k = 0; k < 13; k++) tick();
        rd(2'd2, r); chk("f_count7", r, 32'd7);
        wr(2'd0, 32'h0, 4'hF);
        rd(2'd2, r); chk("f_hold_a", r, 32'd7);
        tick();
        rd(2'd2, r); chk("f_hold_b", r, 32'd7);
        wr(2'd2, 32'h1234, 4'hF);
        rd(2'd2, r); chk("f_count_ro", r, 32'd7);
        wr(2'd0, 32'h9, 4'hF);
        tick();
        rd(2'd2, r); chk("f_reload_e1", r, 32'd7);
        tick();
        rd(2'd2, r); chk("f_reload_e2", r, 32'd20);
        wr(2'd0, 32'h0, 4'hF);

        // Index 3 reads zero and ignores writes
        wr(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd(2'd3, r); chk("idx3", r, 32'd0);

        // Read during write returns the old value
        bus.sel    = 1'b1;
        bus.addr   = 2'd1;
        bus.wdata  = 32'hCAFE_F00D;
        bus.byteen = 4'hF;
        #1;
        chk("rdw_old", bus.rdata, 32'd20);
        tick();
        bus.sel    = 1'b0;
        bus.byteen = 4'd0;
        rd(2'd1, r); chk("rdw_new", r, 32'hCAFE_F00D);

        // Byte-lane write
        wr(2'd1, 32'h1122_3344, 4'hF);
        wr(2'd1, 32'h0000_AA00, 4'b0010);
        rd(2'd1, r);
`ifdef TC_BYTEEN_EN
        chk("be_preset", r, 32'h1122_AA44);
`else
        chk("be_preset", r, 32'h0000_AA00);
`endif

        // Reset mid-count
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd2, r); chk("mr_count", r, 32'd0);
        rd(2'd0, r); chk("mr_ctrl", r, 32'd0);
        rd(2'd1, r); chk("mr_preset", r, 32'd0);
        tick();
        tick();
        rd(2'd2, r); chk("mr_idle", r, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
